mc6809_bus_bridge: RTL and testbench
====================================

# mc6809_bus_bridge

Converts the quadrature E/Q bus cycles of the `mc6809` CPU wrapper into a single-clock request/acknowledge memory port. It sits directly downstream of the CPU wrapper and drives the wrapper's `D` and `MRDY` inputs. Slow memory stretches the CPU cycle through `MRDY`. A timeout guarantees the CPU never hangs.

## Interface
- `ADDR_W`, default 16: address width, matching the CPU `ADDR` bus.
- `TIMEOUT`, default 255: maximum CLK cycles to wait for `mem_ack` before aborting.
- `OPEN_BUS`, default 8'hFF: data returned on timeout and after reset.

Ports:
- `CLK` in 1: the EXTAL clock that also drives the CPU wrapper. The bridge uses the rising edge only.
- `nRESET` in 1: reset, synchronous and active-low.
- `E` in 1: CPU E clock.
- `Q` in 1: CPU Q clock.
- `ADDR` in ADDR_W: CPU address.
- `RnW` in 1: CPU read/not-write.
- `DOut` in 8: CPU write data.
- `BA` in 1: bus available. When `BA`=1 the CPU has released the bus and no request is issued.
- `D` out 8: read data to the CPU. Registered.
- `MRDY` out 1: memory ready to the CPU wrapper. Registered. 0 freezes the E/Q phase counter.
- `mem_req` out 1: memory request. Held high until acknowledged or timed out.
- `mem_we` out 1: 1 = write. Valid while `mem_req`=1.
- `mem_addr` out ADDR_W: latched address.
- `mem_wdata` out 8: latched write data.
- `mem_rdata` in 8: read data. Sampled in the cycle `mem_ack`=1.
- `mem_ack` in 1: single-cycle acknowledge. Ignored when `mem_req`=0.
- `bus_err` out 1: one-cycle pulse when a request times out.

## Operation
- Edge detection: registers `E_d` and `Q_d`.
  - `q_rise` = `Q & ~Q_d`.
  - `e_rise` = `E & ~E_d`.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE:
  - On `q_rise & ~BA & RnW`: latch `ADDR`, then `mem_req`=1, `mem_we`=0, `MRDY`=0, go to RD_WAIT.
  - On `e_rise & ~BA & ~RnW`: latch `ADDR` and `DOut`, then `mem_req`=1, `mem_we`=1, `MRDY`=0, go to WR_WAIT.
  - Write data is captured on E rise, not Q rise, because CPU write data is valid only in the E-high half.
- RD_WAIT:
  - On `mem_ack`: `D` <= `mem_rdata`, `mem_req`=0, `MRDY`=1, go to IDLE.
- WR_WAIT:
  - On `mem_ack`: `mem_req`=0, `MRDY`=1, go to IDLE.
- Timeout counter:
  - Cleared when a request is issued; increments each cycle in a WAIT state.
  - When the count reaches `TIMEOUT` without ack: `bus_err`=1 for one cycle, `MRDY`=1, `mem_req`=0, go to IDLE.
  - A read timeout sets `D` <= `OPEN_BUS`.
- Ack and timeout in the same cycle: ack wins and `bus_err` stays 0.
- `D` holds its value until the next read completes; it is not cleared between cycles.
- `BA` rising while a request is pending does not abort the request; the request completes normally.
- Latched `mem_addr`, `mem_we` and `mem_wdata` do not change while `mem_req`=1.
- Reset values:
  - State IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `MRDY`=1, `D`=`OPEN_BUS`, `bus_err`=0.
  - Counter 0, `E_d`=0, `Q_d`=0.
- Reset mid-request drops `mem_req` immediately, with no ack required. The memory side must tolerate an abandoned request.

## Timing
- `E` and `Q` change on the CLK falling edge and are sampled on the rising edge, so detection latency is half a CLK.
- Request edge: `mem_req` rises on the same edge that detects `q_rise` or `e_rise`, which is edge k.
- Earliest ack: `mem_ack` at edge k+1 gives `MRDY`=1 at k+1.
  - The wrapper samples `MRDY`=0 at the falling edge between k and k+1.
  - A zero-wait access therefore stretches the CPU cycle by exactly one CLK.
- An ack at edge k+n stretches the CPU cycle by n CLKs.
- `D` becomes valid at the ack edge, which is before E falls, because the phase counter is frozen while waiting.
- At most one request per CPU cycle; a full CPU cycle is 4 CLKs unstretched.
- Counter width: clog2(`TIMEOUT`+1). No wrap: the counter saturates and the WAIT state exits at `TIMEOUT`.

## Structure
- Shared package `mc6809_pkg`:
  - State enum (IDLE, RD_WAIT, WR_WAIT).
  - `OPEN_BUS` default constant.
  - Default `TIMEOUT`.
- One sub-module, `mc6809_edge_det`: registers an input and outputs a one-cycle rise pulse. Instantiated for E and Q.
- Top level: FSM, latches and timeout counter. Target about 150–250 lines of RTL.

## Test plan
- Zero-wait read: CPU reads 16'h1234 and memory acks at k+1 with 8'hA5.
  - Required: `mem_req` high for 1 CLK, `mem_we`=0, `MRDY` low for 1 CLK, `D`=8'hA5 before E falls.
- Three-wait write: CPU writes 8'h3C to 16'hFF00 and ack arrives at k+3.
  - Required: `mem_wdata`=8'h3C is stable for 3 CLKs and the CPU cycle stretches by 3 CLKs.
- Timeout: `TIMEOUT`=8, read with no ack.
  - Required: `bus_err` pulses at k+8, `D`=8'hFF, `MRDY`=1, state IDLE.
- Ack on the timeout cycle: ack with 8'h11 at k+8 with `TIMEOUT`=8.
  - Required: `bus_err`=0, `D`=8'h11.
- Bus released: `BA`=1 across a full E/Q cycle.
  - Required: no `mem_req` and `MRDY` stays 1.
- Reset mid-request: `nRESET`=0 at k+2 of a pending read.
  - Required: next edge has `mem_req`=0, `MRDY`=1, `D`=8'hFF; a later ack is ignored.

Source files
------------

// File: rtl/mc6809_pkg.sv
// Shared types and defaults for the mc6809 bus bridge.
// Holds the bridge FSM state type and default parameter values.
package mc6809_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;
    localparam int         TIMEOUT_DEF  = 255;

endpackage

// File: rtl/mc6809_edge_det.sv
// Registers a level and emits a one-cycle pulse on its rising edge.
// Ports: clk, rst_n (sync, active-low), sig in, rise out.
module mc6809_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/mc6809_bus_bridge.sv
// Turns mc6809 E/Q bus cycles into a req/ack memory port, stretching
// the CPU via MRDY while waiting, with a timeout that returns OPEN_BUS.
// Ports: CLK, nRESET (sync, active-low); CPU side E, Q, ADDR, RnW,
// DOut, BA in and D, MRDY out; memory side mem_req, mem_we, mem_addr,
// mem_wdata out and mem_rdata, mem_ack in; bus_err timeout pulse.
module mc6809_bus_bridge
    import mc6809_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEF
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              E,
    input  logic              Q,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              RnW,
    input  logic [7:0]        DOut,
    input  logic              BA,
    output logic [7:0]        D,
    output logic              MRDY,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             q_rise;
    logic             e_rise;
    logic             rd_hit;
    logic             wr_hit;
    logic             tmo;

    mc6809_edge_det u_q_det (
        .clk   (CLK),
        .rst_n (nRESET),
        .sig   (Q),
        .rise  (q_rise)
    );

    mc6809_edge_det u_e_det (
        .clk   (CLK),
        .rst_n (nRESET),
        .sig   (E),
        .rise  (e_rise)
    );

    // Reads start on Q rise; writes wait for E rise, when DOut is valid.
    assign rd_hit = q_rise & ~BA & RnW;
    assign wr_hit = e_rise & ~BA & ~RnW;

    // Saturating count; tmo fires on the cycle the count reaches TIMEOUT.
    assign cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign tmo     = (cnt_nxt == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            MRDY      <= 1'b1;
            D         <= OPEN_BUS;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    unique case (1'b1)
                        rd_hit: begin
                            state    <= ST_RD_WAIT;
                            cnt      <= '0;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= ADDR;
                            MRDY     <= 1'b0;
                        end
                        wr_hit: begin
                            state     <= ST_WR_WAIT;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR;
                            mem_wdata <= DOut;
                            MRDY      <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    cnt <= cnt_nxt;
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        if (state == ST_RD_WAIT) begin
                            D <= mem_rdata;
                        end
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        MRDY    <= 1'b1;
                    end else if (tmo) begin
                        if (state == ST_RD_WAIT) begin
                            D <= OPEN_BUS;
                        end
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        MRDY    <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    MRDY    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc6809_bus_bridge.sv
// Testbench for mc6809_bus_bridge: E/Q wrapper and memory models,
// directed scenarios, then randomized traffic against a reference model.
module tb_mc6809_bus_bridge;

    localparam int TMO = 8;

    logic        clk;
    logic        nRESET;
    logic        E, Q;
    logic [15:0] ADDR;
    logic        RnW;
    logic [7:0]  DOut;
    logic        BA;
    logic [7:0]  D;
    logic        MRDY;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mc6809_bus_bridge #(
        .ADDR_W   (16),
        .TIMEOUT  (TMO),
        .OPEN_BUS (8'hFF)
    ) dut (
        .CLK       (clk),
        .nRESET    (nRESET),
        .E         (E),
        .Q         (Q),
        .ADDR      (ADDR),
        .RnW       (RnW),
        .DOut      (DOut),
        .BA        (BA),
        .D         (D),
        .MRDY      (MRDY),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Stimulus control
    bit          rand_mode = 0;
    bit          ba_hold   = 0;
    bit          stray_ack = 0;
    logic [15:0] nx_addr   = 16'h0000;
    logic        nx_rnw    = 1'b1;
    logic [7:0]  nx_dout   = 8'h00;
    logic        nx_ba     = 1'b1;
    int          dir_lat   = 0;
    logic [7:0]  dir_data  = 8'h00;

    // CPU wrapper: 4-phase E/Q, advancing on falling edges unless MRDY=0
    int ph = 0;
    always @(negedge clk) begin
        if (MRDY) begin
            ph = (ph + 1) % 4;
            if (ph == 0) begin
                if (rand_mode) begin
                    ADDR = 16'($urandom);
                    RnW  = 1'($urandom);
                    DOut = 8'($urandom);
                    BA   = ($urandom_range(0, 4) == 0);
                end else begin
                    ADDR = nx_addr;
                    RnW  = nx_rnw;
                    DOut = nx_dout;
                    BA   = nx_ba;
                end
            end else if (rand_mode && $urandom_range(0, 7) == 0) begin
                BA = ~BA;
            end
        end
        if (ba_hold) BA = 1'b1;
        Q = (ph == 1 || ph == 2);
        E = (ph >= 2);
    end

    // Memory: acks n cycles after seeing the request (n=0 means never)
    int mcnt = 0;
    int mlat = 0;
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (mem_req) begin
            mcnt++;
            if (mcnt == 1)
                mlat = rand_mode ? int'($urandom_range(1, 10)) : dir_lat;
            if (mcnt == mlat) begin
                mem_ack = 1'b1;
                if (!rand_mode) mem_rdata = dir_data;
            end
        end else begin
            mcnt = 0;
        end
        if (stray_ack) mem_ack = 1'b1;
    end

    // Reference model: one outstanding transaction and its age
    bit          m_valid = 0;
    bit          m_busy, m_we, m_err;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_d;
    int          m_age;
    logic        m_qd, m_ed;
    bit          qr, er;

    always @(posedge clk) begin
        qr    = Q && !m_qd;
        er    = E && !m_ed;
        m_qd  = Q;
        m_ed  = E;
        m_err = 0;
        if (!nRESET) begin
            m_busy  = 0;
            m_we    = 0;
            m_addr  = 16'h0;
            m_wdata = 8'h0;
            m_d     = 8'hFF;
            m_age   = 0;
            m_qd    = 0;
            m_ed    = 0;
        end else if (!m_busy) begin
            if (!BA && RnW && qr) begin
                m_busy = 1; m_we = 0; m_addr = ADDR; m_age = 0;
            end else if (!BA && !RnW && er) begin
                m_busy = 1; m_we = 1; m_addr = ADDR;
                m_wdata = DOut; m_age = 0;
            end
        end else begin
            m_age++;
            if (mem_ack) begin
                if (!m_we) m_d = mem_rdata;
                m_busy = 0;
            end else if (m_age == TMO) begin
                m_err = 1;
                if (!m_we) m_d = 8'hFF;
                m_busy = 0;
            end
        end
        m_valid = 1;
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("cmp_req", mem_req, m_busy);
            chk("cmp_mrdy", MRDY, !m_busy);
            chk("cmp_d", D, m_d);
            chk("cmp_err", bus_err, m_err);
            if (m_busy) begin
                chk("cmp_we", mem_we, m_we);
                chk("cmp_addr", mem_addr, m_addr);
                if (m_we) chk("cmp_wdata", mem_wdata, m_wdata);
            end
        end
    end

    task automatic wait_req();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                ok = 1;
                break;
            end
        end
        chk("req_seen", ok, 1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_cyc(input logic [15:0] a, input logic rnw,
                           input logic [7:0] dout, input logic ba,
                           input int lat, input logic [7:0] rd);
        nx_addr  = a;
        nx_rnw   = rnw;
        nx_dout  = dout;
        nx_ba    = ba;
        dir_lat  = lat;
        dir_data = rd;
    endtask

    initial begin
        nRESET = 1'b0;
        E = 1'b0; Q = 1'b0;
        ADDR = 16'h0; RnW = 1'b1; DOut = 8'h0; BA = 1'b1;
        mem_ack = 1'b0; mem_rdata = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_mrdy", MRDY, 1);
        chk("rst_d", D, 8'hFF);
        chk("rst_err", bus_err, 0);
        chk("rst_addr", mem_addr, 16'h0);
        nRESET = 1'b1;

        // Zero-wait read
        set_cyc(16'h1234, 1, 8'h00, 0, 1, 8'hA5);
        wait_req();
        chk("zr_we", mem_we, 0);
        chk("zr_addr", mem_addr, 16'h1234);
        chk("zr_mrdy_lo", MRDY, 0);
        step();
        chk("zr_req_lo", mem_req, 0);
        chk("zr_mrdy_hi", MRDY, 1);
        chk("zr_d", D, 8'hA5);
        chk("zr_e_low", E, 0);

        // Three-wait write
        set_cyc(16'hFF00, 0, 8'h3C, 0, 3, 8'h00);
        wait_req();
        chk("w3_we", mem_we, 1);
        chk("w3_addr", mem_addr, 16'hFF00);
        chk("w3_wd0", mem_wdata, 8'h3C);
        for (int i = 1; i < 3; i++) begin
            step();
            chk("w3_req", mem_req, 1);
            chk("w3_wd", mem_wdata, 8'h3C);
            chk("w3_mrdy", MRDY, 0);
        end
        step();
        chk("w3_done", mem_req, 0);
        chk("w3_mrdy_hi", MRDY, 1);
        chk("w3_frozen_e", E, 1);
        chk("w3_d_kept", D, 8'hA5);

        // Timeout with no ack
        set_cyc(16'h0042, 1, 8'h00, 0, 0, 8'h00);
        wait_req();
        for (int i = 1; i < TMO; i++) begin
            step();
            chk("to_err_lo", bus_err, 0);
            chk("to_req_hi", mem_req, 1);
        end
        step();
        chk("to_err", bus_err, 1);
        chk("to_d", D, 8'hFF);
        chk("to_mrdy", MRDY, 1);
        chk("to_req", mem_req, 0);
        step();
        chk("to_err_pulse", bus_err, 0);

        // Ack on the timeout cycle
        set_cyc(16'h0077, 1, 8'h00, 0, TMO, 8'h11);
        wait_req();
        repeat (TMO) step();
        chk("at_err", bus_err, 0);
        chk("at_d", D, 8'h11);
        chk("at_mrdy", MRDY, 1);
        step();
        chk("at_err2", bus_err, 0);

        // Bus released for read and write cycles
        set_cyc(16'h5555, 1, 8'h00, 1, 1, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) nx_rnw = 0;
            step();
            chk("ba_req", mem_req, 0);
            chk("ba_mrdy", MRDY, 1);
        end

        // Reset during a pending read, then a stray ack
        set_cyc(16'h2222, 1, 8'h00, 0, 0, 8'h00);
        wait_req();
        step();
        chk("rm_pend", mem_req, 1);
        nRESET  = 1'b0;
        ba_hold = 1;
        step();
        chk("rm_req", mem_req, 0);
        chk("rm_mrdy", MRDY, 1);
        chk("rm_d", D, 8'hFF);
        nRESET    = 1'b1;
        stray_ack = 1;
        step();
        stray_ack = 0;
        step();
        chk("rm_ign_req", mem_req, 0);
        chk("rm_ign_d", D, 8'hFF);
        chk("rm_ign_mrdy", MRDY, 1);

        // Randomized traffic
        rand_mode = 1;
        ba_hold   = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            nRESET = ($urandom_range(0, 399) != 0);
        end
        nRESET = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
